ioctl_upload_responder: RTL

//  Upload-direction counterpart of the hps_io ROM/DIP downloader. Services HPS ioctl

---
 rtl/mylstar_pkg.sv | 10 +
 rtl/ioctl_upload_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mylstar_pkg.sv
// Shared types for the MiSTer-style core glue blocks.
//   upload_state_t : states of the ioctl upload responder
//   IOCTL_AW       : width of the hps_io ioctl byte address
package mylstar_pkg;

  typedef enum logic [1:0] {UP_IDLE, UP_FETCH, UP_LAT} upload_state_t;

  localparam int IOCTL_AW = 25;

endpackage

// File: rtl/ioctl_upload_responder.sv
// ioctl_upload_responder
//   Answers HPS ioctl upload reads (core -> HPS, e.g. NVRAM or high-score save)
//   for a single ioctl_index. Each strobed read fetches one byte from a
//   synchronous BRAM read port and presents it on ioctl_din, holding off the
//   HPS with ioctl_wait while the fetch is in flight. Addresses beyond the
//   memory return FILL immediately, without a stall.
//
// Optional feature (macro UPLOAD_CHECKSUM_EN):
//   keeps an 8-bit running sum of the bytes delivered from memory in the
//   current session. The sum is cleared when the session starts, and a read at
//   address DEPTH returns it without a stall.
//
// Ports
//   clk_sys       system clock, rising edge
//   reset_n       asynchronous active-low reset
//   ioctl_upload  HPS upload session active
//   ioctl_index   session target index
//   ioctl_rd      1-clk read strobe from hps_io
//   ioctl_addr    byte address of the strobed read
//   ioctl_din     read data to hps_io
//   ioctl_wait    stall to hps_io while a fetch is in flight
//   mem_addr      BRAM read address
//   mem_rd        1-clk BRAM read enable
//   mem_q         BRAM read data, valid RD_LAT clocks after mem_rd
//   core_hold     registered session-select; freezes the core during upload
//   proto_err     sticky flag: read strobe arrived while a fetch was busy
//
// state    | meaning
// UP_IDLE  | waiting for a read strobe; FILL/checksum reads answered here
// UP_FETCH | mem_rd pulse in flight; latency counter loaded on exit
// UP_LAT   | counting down the BRAM latency, capture mem_q at zero
module ioctl_upload_responder
  import mylstar_pkg::*;
#(
  parameter logic [7:0] INDEX  = 8'd4,
  parameter int         AW     = 10,
  parameter int         RD_LAT = 1,
  parameter logic [7:0] FILL   = 8'h00
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_q,
  output logic                core_hold,
  output logic                proto_err
);

  // Range test runs on the full ioctl address, so nothing above DEPTH aliases.
  localparam logic [IOCTL_AW-1:0] DEPTH    = IOCTL_AW'(1) << AW;
  localparam logic [1:0]          LAT_LOAD = 2'(RD_LAT - 1);

  upload_state_t state_q, state_nxt;
  logic [1:0]    cnt_q, cnt_nxt;
  logic [7:0]    din_nxt;
  logic          wait_nxt;
  logic [AW-1:0] addr_nxt;
  logic          rd_nxt;
  logic          err_nxt;
  logic          sel;

  assign sel = ioctl_upload && (ioctl_index == INDEX);

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       deliver;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= UP_IDLE;
      cnt_q      <= 2'd0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      proto_err  <= 1'b0;
      core_hold  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      ioctl_din  <= din_nxt;
      ioctl_wait <= wait_nxt;
      mem_addr   <= addr_nxt;
      mem_rd     <= rd_nxt;
      proto_err  <= err_nxt;
      core_hold  <= sel;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    din_nxt   = ioctl_din;
    wait_nxt  = ioctl_wait;
    addr_nxt  = mem_addr;
    rd_nxt    = 1'b0;
    err_nxt   = proto_err | (ioctl_rd && sel && (state_q != UP_IDLE));
`ifdef UPLOAD_CHECKSUM_EN
    deliver   = 1'b0;
`endif

    case (state_q)
      UP_IDLE: begin
        if (ioctl_rd && sel) begin
          if (ioctl_addr < DEPTH) begin
            wait_nxt  = 1'b1;
            addr_nxt  = ioctl_addr[AW-1:0];
            rd_nxt    = 1'b1;
            state_nxt = UP_FETCH;
          end else begin
            din_nxt = FILL;
`ifdef UPLOAD_CHECKSUM_EN
            if (ioctl_addr == DEPTH) din_nxt = sum_q;
`endif
          end
        end
      end

      UP_FETCH: begin
        if (!sel) begin
          wait_nxt  = 1'b0;
          state_nxt = UP_IDLE;
        end else begin
          cnt_nxt   = LAT_LOAD;
          state_nxt = UP_LAT;
        end
      end

      UP_LAT: begin
        if (!sel) begin
          // session dropped: release HPS, keep the previous byte on ioctl_din
          wait_nxt  = 1'b0;
          state_nxt = UP_IDLE;
        end else if (cnt_q == 2'd0) begin
          din_nxt   = mem_q;
          wait_nxt  = 1'b0;
          state_nxt = UP_IDLE;
`ifdef UPLOAD_CHECKSUM_EN
          deliver   = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt_q - 2'd1;
        end
      end

      default: begin
        wait_nxt  = 1'b0;
        state_nxt = UP_IDLE;
      end
    endcase
  end

`ifdef UPLOAD_CHECKSUM_EN
  // core_hold is sel delayed one clock, so sel && !core_hold marks session start.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 8'h00;
    end else if (sel && !core_hold) begin
      sum_q <= 8'h00;
    end else if (deliver) begin
      sum_q <= sum_q + mem_q;
    end
  end
`endif

endmodule
